// File: rtl/cd_pkg.sv
// cd_pkg: shared states, BCD limits, reset position and digit incrementer for the CD sector path
package cd_pkg;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_LATCH, S_READY, S_WAIT_DMA, S_PACE} state_t;
  localparam logic [7:0] FRAME_MAX = 8'h74;
  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] MIN_MAX = 8'h99;
  localparam logic [7:0] RST_M = 8'h00;
  localparam logic [7:0] RST_S = 8'h02;
  localparam logic [7:0] RST_F = 8'h00;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'h9) ? {v[7:4] + 4'h1, 4'h0} : v + 8'h1;
  endfunction
endpackage

// File: rtl/msf_bcd_inc.sv
// msf_bcd_inc: combinational next-frame BCD incrementer (F wraps at 74, S at 59, M at 99)
module msf_bcd_inc
  import cd_pkg::*;
(
  input  logic [7:0] m_i,
  input  logic [7:0] s_i,
  input  logic [7:0] f_i,
  output logic [7:0] m_o,
  output logic [7:0] s_o,
  output logic [7:0] f_o
);
  logic f_wrap;
  logic s_wrap;
  assign f_wrap = (f_i == FRAME_MAX);
  assign s_wrap = f_wrap && (s_i == SEC_MAX);
  assign f_o = f_wrap ? 8'h00 : bcd_inc(f_i);
  assign s_o = !f_wrap ? s_i : (s_i == SEC_MAX) ? 8'h00 : bcd_inc(s_i);
  assign m_o = !s_wrap ? m_i : (m_i == MIN_MAX) ? 8'h00 : bcd_inc(m_i);
endmodule

// File: rtl/cd_sector_sequencer.sv
// cd_sector_sequencer: paces sector requests, strobes header latch/ready, waits for DMA.
// Defining CD_SPEED_2X_EN halves the sector period (150 sectors/s).
module cd_sector_sequencer
  import cd_pkg::*;
#(
  parameter int TICK_DIV = 1280000,
  parameter int STRETCH = 16
) (
  input  logic       clk_sys,
  input  logic       RESET,
  input  logic       SEEK,
  input  logic       STOP,
  input  logic [7:0] START_M,
  input  logic [7:0] START_S,
  input  logic [7:0] START_F,
  output logic       SECTOR_REQ,
  input  logic       SECTOR_ACK,
  output logic [7:0] MSF_M,
  output logic [7:0] MSF_S,
  output logic [7:0] MSF_F,
  output logic       MSF_LATCH,
  output logic       SECTOR_READY,
  input  logic       DMA_RUNNING,
  output logic       BUSY,
  output logic       OVERRUN
);
`ifdef CD_SPEED_2X_EN
  localparam int PERIOD = TICK_DIV / 2;
`else
  localparam int PERIOD = TICK_DIV;
`endif
  localparam int TW = $clog2(PERIOD + 1);
  localparam int SW = $clog2(STRETCH + 1);

  state_t state_q, state_d;
  logic [7:0] m_q, m_d, s_q, s_d, f_q, f_d, m_inc, s_inc, f_inc;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [SW-1:0] str_cnt_q, str_cnt_d;
  logic tick_pend_q, tick_pend_d, stop_pend_q, stop_pend_d;
  logic dma_prev_q, dma_seen_q, dma_seen_d, overrun_q, overrun_d;
  logic req_q, req_d, latch_q, latch_d, ready_q, ready_d, busy_q, busy_d;
  logic tick, str_done, dma_rise, dma_fall, advance;

  msf_bcd_inc u_inc (
    .m_i(m_q), .s_i(s_q), .f_i(f_q),
    .m_o(m_inc), .s_o(s_inc), .f_o(f_inc)
  );

  assign tick = busy_q && (tick_cnt_q == TW'(PERIOD - 1));
  assign str_done = (str_cnt_q == SW'(STRETCH - 1));
  assign dma_rise = DMA_RUNNING && !dma_prev_q;
  assign dma_fall = !DMA_RUNNING && dma_prev_q;

  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    m_d = m_q;
    s_d = s_q;
    f_d = f_q;
    overrun_d = overrun_q;
    dma_seen_d = dma_seen_q;
    stop_pend_d = stop_pend_q | (STOP & (state_q inside {S_REQ, S_LATCH, S_READY}));
    tick_pend_d = tick_pend_q | tick;
    str_cnt_d = ((state_q inside {S_LATCH, S_READY}) && !str_done) ? str_cnt_q + 1'b1 : '0;
    tick_cnt_d = (SEEK || !busy_q || tick) ? '0 : tick_cnt_q + 1'b1;
    case (state_q)
      S_REQ:   if (SECTOR_ACK) state_d = stop_pend_d ? S_IDLE : S_LATCH;
      S_LATCH: if (str_done) state_d = stop_pend_d ? S_IDLE : S_READY;
      S_READY: if (str_done) state_d = stop_pend_d ? S_IDLE : S_WAIT_DMA;
      // a tick here means the DMA missed its window: drop this sector and move on
      S_WAIT_DMA:
        if (STOP) state_d = S_IDLE;
        else if (tick) begin
          overrun_d = 1'b1;
          advance = 1'b1;
        end else if (dma_rise) dma_seen_d = 1'b1;
        else if (dma_fall && dma_seen_q) state_d = S_PACE;
      S_PACE:
        if (STOP) state_d = S_IDLE;
        else if (tick_pend_d) advance = 1'b1;
      default: ;
    endcase
    if (advance) begin
      state_d = S_REQ;
      m_d = m_inc;
      s_d = s_inc;
      f_d = f_inc;
      tick_pend_d = 1'b0;
    end
    if (state_d == S_IDLE) begin
      stop_pend_d = 1'b0;
      tick_pend_d = 1'b0;
    end
    if (state_d != S_WAIT_DMA) dma_seen_d = 1'b0;
    if (SEEK) begin
      state_d = S_REQ;
      m_d = START_M;
      s_d = START_S;
      f_d = START_F;
      overrun_d = 1'b0;
      stop_pend_d = 1'b0;
      tick_pend_d = 1'b0;
      dma_seen_d = 1'b0;
    end
    req_d = (state_d == S_REQ);
    latch_d = (state_d == S_LATCH);
    ready_d = (state_d == S_READY);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      state_q <= S_IDLE;
      m_q <= RST_M;
      s_q <= RST_S;
      f_q <= RST_F;
      tick_cnt_q <= '0;
      str_cnt_q <= '0;
      tick_pend_q <= 1'b0;
      stop_pend_q <= 1'b0;
      dma_prev_q <= 1'b0;
      dma_seen_q <= 1'b0;
      overrun_q <= 1'b0;
      req_q <= 1'b0;
      latch_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q <= m_d;
      s_q <= s_d;
      f_q <= f_d;
      tick_cnt_q <= tick_cnt_d;
      str_cnt_q <= str_cnt_d;
      tick_pend_q <= tick_pend_d;
      stop_pend_q <= stop_pend_d;
      dma_prev_q <= DMA_RUNNING;
      dma_seen_q <= dma_seen_d;
      overrun_q <= overrun_d;
      req_q <= req_d;
      latch_q <= latch_d;
      ready_q <= ready_d;
      busy_q <= busy_d;
    end
  end

  assign SECTOR_REQ = req_q;
  assign MSF_LATCH = latch_q;
  assign SECTOR_READY = ready_q;
  assign BUSY = busy_q;
  assign OVERRUN = overrun_q;
  assign MSF_M = m_q;
  assign MSF_S = s_q;
  assign MSF_F = f_q;
endmodule

// File: tb/tb_cd_sector_sequencer.sv
// tb_cd_sector_sequencer: randomized sector runs checked by a scoreboard against a frame-index MSF model
module tb_cd_sector_sequencer;
  localparam int TICK_DIV = 400;
  localparam int STRETCH = 16;
`ifdef CD_SPEED_2X_EN
  localparam int PERIOD = TICK_DIV / 2;
`else
  localparam int PERIOD = TICK_DIV;
`endif

  logic clk_sys = 1'b0, RESET = 1'b1, SEEK = 1'b0, STOP = 1'b0, SECTOR_ACK = 1'b0, DMA_RUNNING = 1'b0;
  logic [7:0] START_M = 8'h0, START_S = 8'h0, START_F = 8'h0;
  logic [7:0] MSF_M, MSF_S, MSF_F;
  logic SECTOR_REQ, MSF_LATCH, SECTOR_READY, BUSY, OVERRUN;
  int total = 0, bad = 0;

  typedef struct {
    logic [23:0] msf;
    logic        ov;
    int          off;
  } exp_t;
  exp_t sb[$];

  always #5 clk_sys = ~clk_sys;

  cd_sector_sequencer #(.TICK_DIV(TICK_DIV), .STRETCH(STRETCH)) dut (
    .clk_sys(clk_sys), .RESET(RESET), .SEEK(SEEK), .STOP(STOP),
    .START_M(START_M), .START_S(START_S), .START_F(START_F),
    .SECTOR_REQ(SECTOR_REQ), .SECTOR_ACK(SECTOR_ACK),
    .MSF_M(MSF_M), .MSF_S(MSF_S), .MSF_F(MSF_F),
    .MSF_LATCH(MSF_LATCH), .SECTOR_READY(SECTOR_READY),
    .DMA_RUNNING(DMA_RUNNING), .BUSY(BUSY), .OVERRUN(OVERRUN)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int bcd2i(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] i2bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  function automatic logic [23:0] next_msf(input logic [23:0] p);
    int idx;
    idx = (bcd2i(p[23:16]) * 4500 + bcd2i(p[15:8]) * 75 + bcd2i(p[7:0]) + 1) % 450000;
    return {i2bcd(idx / 4500), i2bcd((idx / 75) % 60), i2bcd(idx % 75)};
  endfunction

  function automatic logic [23:0] rand_msf();
    return {i2bcd(int'($urandom_range(99))), i2bcd(int'($urandom_range(59))), i2bcd(int'($urandom_range(74)))};
  endfunction

  function automatic logic sig(input int sel);
    return (sel == 0) ? SECTOR_REQ : SECTOR_READY;
  endfunction

  int cyc = 0, base = 0, lat_n = 0, rdy_n = 0;
  logic prev_req = 1'b0, prev_lat = 1'b0, prev_rdy = 1'b0;
  logic [23:0] cur_msf = 24'h000200;
  exp_t e;

  always @(negedge clk_sys) begin
    if (!RESET) begin
      cyc++;
      if (SECTOR_REQ && !prev_req) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_req: got REQ at %h want none", {MSF_M, MSF_S, MSF_F});
        end else begin
          e = sb.pop_front();
          chk("req_msf", {8'h0, MSF_M, MSF_S, MSF_F}, {8'h0, e.msf});
          chk("req_overrun", 32'(OVERRUN), 32'(e.ov));
          if (e.off == 0) base = cyc;
          else chk("req_period", cyc - base, e.off);
          cur_msf = e.msf;
        end
      end
      if (MSF_LATCH && !prev_lat) chk("latch_msf", {8'h0, MSF_M, MSF_S, MSF_F}, {8'h0, cur_msf});
      if (SECTOR_READY && !prev_rdy) chk("ready_msf", {8'h0, MSF_M, MSF_S, MSF_F}, {8'h0, cur_msf});
      lat_n = MSF_LATCH ? lat_n + 1 : lat_n;
      rdy_n = SECTOR_READY ? rdy_n + 1 : rdy_n;
      if (!MSF_LATCH && prev_lat) begin
        chk("latch_len", lat_n, STRETCH);
        chk("ready_follows", 32'(SECTOR_READY), 1);
        lat_n = 0;
      end
      if (!SECTOR_READY && prev_rdy) begin
        chk("ready_len", rdy_n, STRETCH);
        rdy_n = 0;
      end
      prev_req = SECTOR_REQ;
      prev_lat = MSF_LATCH;
      prev_rdy = SECTOR_READY;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic wait_for(input int sel, input logic val, input string nm);
    for (int i = 0; i < 2 * PERIOD && sig(sel) !== val; i++) @(negedge clk_sys);
    if (sig(sel) !== val) begin
      total++;
      bad++;
      $display("FAIL timeout_%s: got %b want %b", nm, sig(sel), val);
    end
  endtask

  task automatic pulse_seek(input logic [23:0] p);
    {START_M, START_S, START_F} = p;
    sb.push_back('{msf: p, ov: 1'b0, off: 0});
    SEEK = 1'b1;
    @(negedge clk_sys);
    SEEK = 1'b0;
  endtask

  task automatic run(input logic [23:0] start, input int n, input int nodma, input bit stop_rdy);
    logic [23:0] pos;
    logic ov;
    int d;
    pos = start;
    ov = 1'b0;
    pulse_seek(start);
    for (int k = 0; k < n; k++) begin
      wait_for(0, 1'b1, "req");
      d = (k == 0 && start == 24'h000200) ? 10 : int'($urandom_range(2, 9));
      if (d != 10 && $urandom_range(1) == 1) begin
        DMA_RUNNING = 1'b1;
        tick(1);
        DMA_RUNNING = 1'b0;
        d--;
      end
      tick(d);
      SECTOR_ACK = 1'b1;
      @(negedge clk_sys);
      SECTOR_ACK = 1'b0;
      wait_for(1, 1'b1, "ready_rise");
      if (stop_rdy && k == n - 1) begin
        STOP = 1'b1;
        @(negedge clk_sys);
        STOP = 1'b0;
        wait_for(1, 1'b0, "ready_fall");
        tick(2);
        chk("busy_after_stop_ready", 32'(BUSY), 0);
        tick(PERIOD + 20);
        return;
      end
      wait_for(1, 1'b0, "ready_fall");
      if (nodma[k]) ov = 1'b1;
      else begin
        tick(int'($urandom_range(5)));
        DMA_RUNNING = 1'b1;
        tick((k == 0 && start == 24'h000200) ? 100 : int'($urandom_range(5, 100)));
        DMA_RUNNING = 1'b0;
      end
      pos = next_msf(pos);
      sb.push_back('{msf: pos, ov: ov, off: (k + 1) * PERIOD});
    end
    wait_for(0, 1'b1, "req_last");
    STOP = 1'b1;
    @(negedge clk_sys);
    STOP = 1'b0;
    tick(3);
    chk("req_held_on_stop", 32'(SECTOR_REQ), 1);
    SECTOR_ACK = 1'b1;
    @(negedge clk_sys);
    SECTOR_ACK = 1'b0;
    tick(2);
    chk("busy_after_stop_req", 32'(BUSY), 0);
    chk("no_latch_after_stop", 32'(MSF_LATCH), 0);
  endtask

  initial begin
    repeat (60000) @(posedge clk_sys);
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    tick(3);
    chk("rst_req", 32'(SECTOR_REQ), 0);
    chk("rst_latch", 32'(MSF_LATCH), 0);
    chk("rst_ready", 32'(SECTOR_READY), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_overrun", 32'(OVERRUN), 0);
    chk("rst_msf", {8'h0, MSF_M, MSF_S, MSF_F}, 32'h000200);
    RESET = 1'b0;
    tick(2);
    chk("idle_busy", 32'(BUSY), 0);
    run(24'h000200, 2, 0, 1'b0);
    run(24'h005974, 1, 0, 1'b0);
    run(24'h995974, 1, 0, 1'b0);
    run(rand_msf(), 3, 2, 1'b0);
    run(rand_msf(), 2, 0, 1'b1);
    for (int i = 0; i < 3; i++) run(rand_msf(), 2, int'($urandom_range(3)), 1'b0);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
